// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the load/store unit:
//     - RegBus / MemAddrBus widths
//     - funct3 encodings for loads and stores
//     - 2-bit FSM state encoding (IDLE=0, ACCESS=1, READ=2, DONE=3)
//     - access-size decode helper used by the lane logic
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Bus widths
    localparam int REG_BUS_W      = 32;
    localparam int MEM_ADDR_BUS_W = 32;

    // funct3 encodings: loads
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3 encodings: stores
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_READ   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Access size derived from funct3
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Any funct3 value that is not a recognised byte/half op falls back to a
    // full-word access, which covers the reserved codes.
    function automatic size_t op_size(input logic we, input logic [2:0] op);
        size_t sz;
        sz = SZ_WORD;
        if (we) begin
            case (op)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                F3_SW:   sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (op)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                F3_LW:         sz = SZ_WORD;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    // Only LB and LH sign-extend; every other load zero-extends (LW is full
    // width so the choice does not matter there).
    function automatic logic op_signed(input logic we, input logic [2:0] op);
        return !we && ((op == F3_LB) || (op == F3_LH));
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
//   Purely combinational lane logic for the load/store unit.
//   Little-endian: lane 0 = bits 7:0.
//
// Ports
//   we          in   1   1 = store, 0 = load
//   op          in   3   funct3 code
//   addr_lo     in   2   low byte-address bits
//   wdata       in  32   right-justified store data
//   rdata       in  32   raw word returned by the ram
//   sel         out  4   byte-lane enables
//   wdata_lane  out 32   store data replicated onto the addressed lanes
//   rdata_ext   out 32   addressed lane(s) shifted to bit 0 and extended
//   misaligned  out  1   half with addr[0]=1 or word with addr[1:0]!=0
//
// The lane select ignores addr[0] for halves and addr[1:0] for words, so an
// unaligned access with no misalignment trap lands on the containing aligned
// half or word.
// -----------------------------------------------------------------------------
module mem_align
    import mem_ctrl_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    size_t       size;
    logic        sext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        size       = op_size(we, op);
        sext       = op_signed(we, op);
        rd_byte    = rdata[{addr_lo, 3'b000} +: 8];
        rd_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sel        = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;

        case (size)
            SZ_BYTE: begin
                sel        = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = sext ? {{24{rd_byte[7]}}, rd_byte}
                                  : {24'd0, rd_byte};
            end
            SZ_HALF: begin
                sel        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = sext ? {{16{rd_half[15]}}, rd_half}
                                  : {16'd0, rd_half};
                misaligned = addr_lo[0];
            end
            default: begin
                sel        = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Load/store unit between the CPU MEM stage and the data ram. Takes one
//   request at a time, stalls the pipeline while it is in flight, drives the
//   ram through registered controls and returns a one-cycle response.
//
//   Sequence: IDLE -> ACCESS -> (READ, loads only) -> DONE -> IDLE.
//   Store latency 2 cycles after accept, load latency 3.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
//   req_ready is high only in IDLE; req_* are don't-care at any other time and
//   are sampled only on the accepting edge. resp_valid is a one-cycle pulse
//   with no back-pressure; resp_rdata holds until the next response.
//
// Configuration
//   MEM_CTRL_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses
//                               skip the ram (mem_ce stays 0), finish in two
//                               cycles and report resp_err=1, resp_rdata=0.
//                               When undefined resp_err is always 0.
//
// Ports
//   clk, rst                     clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_we, req_op, req_addr,
//   req_wdata                    request payload
//   resp_valid, resp_rdata,
//   resp_err                     response
//   stall_req                    pipeline stall
//   mem_ce, mem_we, mem_addr,
//   mem_sel, mem_data_o          registered ram controls
//   mem_data_i                   ram read data (cycle after ce=1, we=0)
//   dbg_state                    current FSM state
// -----------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BUS_W,
    parameter int DATA_W = REG_BUS_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall_req,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [1:0]        dbg_state
);

    state_t      state;

    // Request fields latched on accept
    logic        we_q;
    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic        mis_q;

    // Lane logic inputs: live request while IDLE (to build the ram controls
    // on the accepting edge), latched request afterwards (to extract data).
    logic        a_we;
    logic [2:0]  a_op;
    logic [1:0]  a_addr_lo;
    logic [3:0]  a_sel;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        a_mis;
    logic        mis_now;

    assign a_we      = (state == ST_IDLE) ? req_we        : we_q;
    assign a_op      = (state == ST_IDLE) ? req_op        : op_q;
    assign a_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

    mem_align u_align (
        .we         (a_we),
        .op         (a_op),
        .addr_lo    (a_addr_lo),
        .wdata      (req_wdata),
        .rdata      (mem_data_i),
        .sel        (a_sel),
        .wdata_lane (a_wdata),
        .rdata_ext  (a_rdata),
        .misaligned (a_mis)
    );

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    assign mis_now = a_mis;
`else
    // Unaligned accesses go to the containing aligned half/word instead.
    logic unused_mis;
    assign unused_mis = a_mis;
    assign mis_now    = 1'b0;
`endif

    assign req_ready = (state == ST_IDLE);
    // Released in DONE so the pipeline advances in the response cycle.
    assign stall_req = ((state == ST_IDLE) && req_valid)
                     || (state == ST_ACCESS)
                     || (state == ST_READ);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            op_q       <= 3'b000;
            addr_lo_q  <= 2'b00;
            mis_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_sel    <= 4'b0000;
            mem_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        state      <= ST_ACCESS;
                        we_q       <= req_we;
                        op_q       <= req_op;
                        addr_lo_q  <= req_addr[1:0];
                        mis_q      <= mis_now;
                        // A trapped access never reaches the ram.
                        mem_ce     <= !mis_now;
                        mem_we     <= req_we && !mis_now;
                        mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                        mem_sel    <= a_sel;
                        mem_data_o <= req_we ? a_wdata : '0;
                    end
                end

                ST_ACCESS: begin
                    // The ram performs the access on this edge.
                    mem_ce <= 1'b0;
                    mem_we <= 1'b0;
                    if (we_q || mis_q) begin
                        state      <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= mis_q;
                    end else begin
                        state <= ST_READ;
                    end
                end

                ST_READ: begin
                    state      <= ST_DONE;
                    resp_valid <= 1'b1;
                    resp_rdata <= a_rdata;
                    resp_err   <= 1'b0;
                end

                ST_DONE: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall_req;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic [1:0]  dbg_state;

  mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall_req  (stall_req),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_sel    (mem_sel),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- ram model
  logic        preload;
  logic [31:0] ram [0:255];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[8'h40] <= 32'hCAFE_F00D;
      ram[8'h41] <= 32'h8000_FF80;
      ram[8'h80] <= 32'h1122_3344;
      ram[8'hC0] <= 32'h55AA_55AA;
    end else if (mem_ce) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_sel[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_data_o[b*8 +: 8];
      end else begin
        mem_data_i <= ram[mem_addr[9:2]];
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  // Values observed during the ACCESS cycle of the last transaction
  logic        acc_ce;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [3:0]  acc_sel;
  logic [31:0] acc_data;
  logic        ce_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Issue one request, wait for its response and check latency, data and
  // error flag. Request inputs are scrambled right after accept.
  task automatic issue(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat);
    int n;
    int lat;
    logic [31:0] exp_v;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":accept_wait"}, (n < 20) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_op    = ~op;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    exp_q.push_back(exp_rdata);
    lat     = 0;
    ce_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      ce_seen = ce_seen | mem_ce;
      if (lat == 1) begin
        acc_ce   = mem_ce;
        acc_we   = mem_we;
        acc_addr = mem_addr;
        acc_sel  = mem_sel;
        acc_data = mem_data_o;
      end
    end while (!resp_valid && lat < 8);
    exp_v = exp_q.pop_front();
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":rdata"}, resp_rdata, exp_v);
    check({tag, ":err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, ":pulse_1cyc"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ":rdata_hold"}, resp_rdata, exp_v);
  endtask

  // ---------------------------------------------------------------- stimulus
  int seen_resp;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    preload   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst:req_ready", {31'd0, req_ready}, 32'd1);
    check("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst:stall", {31'd0, stall_req}, 32'd0);
    check("rst:mem_ce", {31'd0, mem_ce}, 32'd0);
    check("rst:mem_we", {31'd0, mem_we}, 32'd0);
    check("rst:mem_addr", mem_addr, 32'h0);
    check("rst:mem_sel", {28'd0, mem_sel}, 32'h0);
    check("rst:mem_data_o", mem_data_o, 32'h0);
    check("rst:rdata", resp_rdata, 32'h0);
    check("rst:err", {31'd0, resp_err}, 32'd0);
    check("rst:state", {30'd0, dbg_state}, 32'd0);
    preload = 1'b0;
    rst     = 1'b1;

    // SW 0xDEADBEEF -> 0x100
    issue("sw100", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    check("sw100:acc_ce", {31'd0, acc_ce}, 32'd1);
    check("sw100:acc_we", {31'd0, acc_we}, 32'd1);
    check("sw100:acc_addr", acc_addr, 32'h100);
    check("sw100:acc_sel", {28'd0, acc_sel}, 32'hF);
    check("sw100:acc_data", acc_data, 32'hDEAD_BEEF);
    check("sw100:ram", ram[8'h40], 32'hDEAD_BEEF);

    // Loads from 0x8000_FF80 at 0x104
    issue("lb104", 1'b0, 3'b000, 32'h104, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    check("lb104:acc_we", {31'd0, acc_we}, 32'd0);
    check("lb104:acc_sel", {28'd0, acc_sel}, 32'h1);
    check("lb104:acc_addr", acc_addr, 32'h104);
    issue("lbu104", 1'b0, 3'b100, 32'h104, 32'h0, 32'h0000_0080, 1'b0, 3);
    issue("lh106", 1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFF_8000, 1'b0, 3);
    check("lh106:acc_sel", {28'd0, acc_sel}, 32'hC);
    check("lh106:acc_addr", acc_addr, 32'h104);
    issue("lhu106", 1'b0, 3'b101, 32'h106, 32'h0, 32'h0000_8000, 1'b0, 3);
    issue("lbu105", 1'b0, 3'b100, 32'h105, 32'h0, 32'h0000_00FF, 1'b0, 3);
    issue("lb107", 1'b0, 3'b000, 32'h107, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    issue("lh104", 1'b0, 3'b001, 32'h104, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    issue("lw_rsvd011", 1'b0, 3'b011, 32'h104, 32'h0, 32'h8000_FF80, 1'b0, 3);

    // SB 0xAB -> 0x203, then read back the merged word
    issue("sb203", 1'b1, 3'b000, 32'h203, 32'h1234_56AB, 32'h0, 1'b0, 2);
    check("sb203:acc_sel", {28'd0, acc_sel}, 32'h8);
    check("sb203:acc_data", acc_data, 32'hABAB_ABAB);
    check("sb203:acc_addr", acc_addr, 32'h200);
    issue("lw200a", 1'b0, 3'b010, 32'h200, 32'h0, 32'hAB22_3344, 1'b0, 3);

    // SH 0x1234 -> 0x202
    issue("sh202", 1'b1, 3'b001, 32'h202, 32'h5678_1234, 32'h0, 1'b0, 2);
    check("sh202:acc_sel", {28'd0, acc_sel}, 32'hC);
    check("sh202:acc_data", acc_data, 32'h1234_1234);
    issue("lw200b", 1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_3344, 1'b0, 3);
    issue("lhu202", 1'b0, 3'b101, 32'h202, 32'h0, 32'h0000_1234, 1'b0, 3);

    // Misaligned LW 0x102
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    issue("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 2);
    check("lw102:ce_never", {31'd0, ce_seen}, 32'd0);
`else
    issue("lw102", 1'b0, 3'b010, 32'h102, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    check("lw102:acc_addr", acc_addr, 32'h100);
    check("lw102:ce_seen", {31'd0, ce_seen}, 32'd1);
`endif

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'h104;
    #1;
    check("b2b:idle_stall", {31'd0, stall_req}, 32'd1);
    check("b2b:idle_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    req_op   = 3'b100;
    req_addr = 32'h105;
    check("b2b:acc_state", {30'd0, dbg_state}, 32'd1);
    check("b2b:acc_stall", {31'd0, stall_req}, 32'd1);
    check("b2b:acc_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b:rd_state", {30'd0, dbg_state}, 32'd2);
    check("b2b:rd_stall", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    check("b2b:done_state", {30'd0, dbg_state}, 32'd3);
    check("b2b:done_stall", {31'd0, stall_req}, 32'd0);
    check("b2b:done_ready", {31'd0, req_ready}, 32'd0);
    check("b2b:resp1_valid", {31'd0, resp_valid}, 32'd1);
    check("b2b:resp1_data", resp_rdata, 32'hFFFF_FF80);
    @(negedge clk);
    check("b2b:gap_state", {30'd0, dbg_state}, 32'd0);
    check("b2b:gap_ready", {31'd0, req_ready}, 32'd1);
    check("b2b:gap_stall", {31'd0, stall_req}, 32'd1);
    check("b2b:gap_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("b2b:acc2_state", {30'd0, dbg_state}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b:resp2_valid", {31'd0, resp_valid}, 32'd1);
    check("b2b:resp2_data", resp_rdata, 32'h0000_00FF);

    // Reset during ACCESS of a store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_op    = 3'b010;
    req_addr  = 32'h300;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid:ce_before", {31'd0, mem_ce}, 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid:ce", {31'd0, mem_ce}, 32'd0);
    check("rstmid:we", {31'd0, mem_we}, 32'd0);
    check("rstmid:ready", {31'd0, req_ready}, 32'd1);
    check("rstmid:state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    check("rstmid:no_resp", seen_resp, 32'd0);
    check("rstmid:ram", ram[8'hC0], 32'h55AA_55AA);
    issue("lw300", 1'b0, 3'b010, 32'h300, 32'h0, 32'h55AA_55AA, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
